// File: rtl/shift_seq_n.sv
// Parameterised shift register with an IDLE/SHIFT/DONE sequencer.
// It supports parallel load, single-step shifts and multi-step shift sequences.
module shift_seq_n #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic [CW-1:0]    count_i,
  input  logic [1:0]       mode_i,
  input  logic             shift_in_i,
  input  logic             shift_en_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             shift_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0]    MODE_LSR = 2'b00;
  localparam logic [1:0]    MODE_LSL = 2'b01;
  localparam logic [1:0]    MODE_ASR = 2'b10;
  localparam logic [1:0]    MODE_ROR = 2'b11;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, done_q;
  logic [1:0]       active_mode_s;

  // One single-bit shift step in the selected mode.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] data,
    input logic [1:0]       mode,
    input logic             fill
  );
    logic [WIDTH-1:0] res;
    case (mode)
      MODE_LSR: res = {fill, data[WIDTH-1:1]};
      MODE_LSL: res = {data[WIDTH-2:0], fill};
      MODE_ASR: res = {data[WIDTH-1], data[WIDTH-1:1]};
      MODE_ROR: res = {data[0], data[WIDTH-1:1]};
      default:  res = data;
    endcase
    return res;
  endfunction

  // Sequencer next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          data_d = d_i;
        end else if (start_i) begin
          if (count_i != CNT_ZERO) begin
            mode_d      = mode_i;
            remaining_d = count_i;
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (shift_en_i) begin
          data_d = shift_step(data_q, mode_i, shift_in_i);
        end else begin
          data_d = data_q;
        end
      end
      ST_SHIFT: begin
        data_d      = shift_step(data_q, mode_q, shift_in_i);
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      data_q      <= {WIDTH{1'b0}};
      remaining_q <= CNT_ZERO;
      mode_q      <= MODE_LSR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      busy_q      <= (state_d == ST_SHIFT);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Outgoing bit follows the latched mode only while a sequence runs.
  always_comb begin
    active_mode_s = (state_q == ST_SHIFT) ? mode_q : mode_i;
    if (active_mode_s == MODE_LSL) begin
      shift_out_o = data_q[WIDTH-1];
    end else begin
      shift_out_o = data_q[0];
    end
  end

  assign data_out_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_shift_seq_n.sv
// Directed self-checking bench for shift_seq_n (WIDTH=8, CW=4).
module tb_shift_seq_n;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic [3:0] count;
  logic [1:0] mode;
  logic       shift_in;
  logic       shift_en;
  logic [7:0] data_out;
  logic       shift_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  shift_seq_n #(.WIDTH(8), .CW(4)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .load_i     (load),
    .d_i        (d),
    .start_i    (start),
    .count_i    (count),
    .mode_i     (mode),
    .shift_in_i (shift_in),
    .shift_en_i (shift_en),
    .data_out_o (data_out),
    .shift_out_o(shift_out),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1;
    d    = val;
    tick();
    load = 1'b0;
    checks++;
    if (data_out !== val) begin
      errors++;
      $display("FAIL load: data_out=%h expected=%h", data_out, val);
    end
  endtask

  // Runs a sequence from IDLE; checks Busy/Done timing and the final data.
  task automatic run_seq(input string name, input logic [1:0] m, input logic [3:0] n,
                         input logic sin, input logic [7:0] exp_data);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    mode     = m;
    count    = n;
    shift_in = sin;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick();
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++;
      $display("FAIL %s data: got=%h expected=%h", name, data_out, exp_data);
    end
    checks++;
    if (busy_cnt != n || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: cycles=%0d expected=%0d busy_now=%b", name, busy_cnt, n, busy);
    end
    checks++;
    if (done !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL %s done_edge: done=%b early=%0d expected 1/0", name, done, done_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%b expected=0", name, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load = 1'b0; d = 8'h00; start = 1'b0; count = 4'd0;
    mode = 2'b00; shift_in = 1'b0; shift_en = 1'b0;
    #12;
    checks++;
    if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shift_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h busy=%b done=%b so=%b expected 00/0/0/0",
               data_out, busy, done, shift_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_lsr();
    do_load(8'hA5);
    run_seq("lsr3", 2'b00, 4'd3, 1'b0, 8'h14);
  endtask

  task automatic test_asr_lsl();
    do_load(8'h90);
    run_seq("asr2", 2'b10, 4'd2, 1'b0, 8'hE4);
    do_load(8'h0F);
    run_seq("lsl4", 2'b01, 4'd4, 1'b1, 8'hFF);
    checks++;
    if (shift_out !== 1'b1) begin
      errors++;
      $display("FAIL lsl4 shift_out: got=%b expected=1", shift_out);
    end
  endtask

  task automatic test_rotate();
    do_load(8'h81);
    mode = 2'b11; count = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 2'b01;
    tick();
    checks++;
    if (data_out !== 8'hC0 || shift_out !== 1'b0) begin
      errors++;
      $display("FAIL ror latched mode: data=%h so=%b expected C0/0", data_out, shift_out);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (data_out !== 8'hC0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ror9: data=%h done=%b expected C0/1", data_out, done);
    end
    tick();
  endtask

  task automatic test_shift_out_idle();
    do_load(8'h80);
    mode = 2'b01;
    #1;
    checks++;
    if (shift_out !== 1'b1) begin
      errors++;
      $display("FAIL so_idle_lsl: got=%b expected=1", shift_out);
    end
    mode = 2'b00;
    #1;
    checks++;
    if (shift_out !== 1'b0) begin
      errors++;
      $display("FAIL so_idle_lsr: got=%b expected=0", shift_out);
    end
  endtask

  task automatic test_count_zero();
    do_load(8'h5A);
    count = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h5A) begin
      errors++;
      $display("FAIL count0: done=%b busy=%b data=%h expected 1/0/5A", done, busy, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL count0 end: done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; d = 8'h77; start = 1'b1; count = 4'd3; mode = 2'b00;
    tick();
    load = 1'b0; start = 1'b0;
    checks++;
    if (data_out !== 8'h77 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_prio: data=%h busy=%b done=%b expected 77/0/0", data_out, busy, done);
    end
  endtask

  task automatic test_ignore_busy();
    do_load(8'h3C);
    mode = 2'b01; count = 4'd2; shift_in = 1'b0; start = 1'b1;
    tick();
    load = 1'b1; d = 8'hFF; mode = 2'b00; count = 4'd7; shift_en = 1'b1;
    tick();
    tick();
    checks++;
    if (data_out !== 8'hF0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: data=%h done=%b expected F0/1", data_out, done);
    end
    load = 1'b0; start = 1'b0; shift_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    done_seen = 0;
    do_load(8'hC3);
    mode = 2'b00; count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h busy=%b done=%b expected 00/0/0", data_out, busy, done);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL abort: activity=%0d data=%h expected 0/00", done_seen, data_out);
    end
  endtask

  task automatic test_shift_en();
    int done_seen;
    done_seen = 0;
    do_load(8'h00);
    shift_en = 1'b1; mode = 2'b00; shift_in = 1'b1;
    tick();
    checks++;
    if (data_out !== 8'h80) begin
      errors++;
      $display("FAIL shift_en step1: got=%h expected=80", data_out);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    shift_en = 1'b0;
    checks++;
    if (data_out !== 8'hFF || done_seen != 0) begin
      errors++;
      $display("FAIL shift_en fill: data=%h activity=%0d expected FF/0", data_out, done_seen);
    end
  endtask

  task automatic test_back_to_back();
    do_load(8'hF0);
    mode = 2'b00; count = 4'd1; shift_in = 1'b0; start = 1'b1;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || data_out !== 8'h78) begin
      errors++;
      $display("FAIL b2b first: done=%b data=%h expected 1/78", done, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: done=%b busy=%b expected 0/0", done, busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_out !== 8'h78) begin
      errors++;
      $display("FAIL b2b restart: busy=%b data=%h expected 1/78", busy, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b1 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL b2b second: done=%b data=%h expected 1/3C", done, data_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lsr();
    test_asr_lsl();
    test_rotate();
    test_shift_out_idle();
    test_count_zero();
    test_load_priority();
    test_ignore_busy();
    test_reset_mid_shift();
    test_shift_en();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
